stream_merge_rr_sched: RTL
==========================

Name: stream_merge_rr_sched

Overview:
- Synchronous round-robin scheduler in front of the 9-way mutex stream merge.
- The merge has no arbitration of its own. It only works when its drives are mutually exclusive, and its data mux is priority-ordered.
- This block turns level requests from up to N_REQ synchronous producers into one-at-a-time drive pulses toward the merge. It waits for the merge's per-input free, acks the producer, then inserts a recovery gap.
- Includes a free timeout watchdog and spurious-free detection.

Parameters:
- N_REQ, 9, number of requesters / merge inputs (2..16).
- IDX_W, $clog2(N_REQ), grant index width (derived, not overridable).
- TIMEOUT, 1024, cycles to wait for free before abort (>=4).
- GAP_CYC, 2, idle cycles after each transaction before next grant (>=1).
- SYNC_STAGES, 2, synchronizer flops on i_free (>=2).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  N_REQ  level request per producer; held until o_ack.
- o_ack  out  N_REQ  one-cycle pulse: transaction for that index completed.
- o_drive  out  N_REQ  one-hot registered pulse to merge i_driveK.
- i_free  in  N_REQ  merge o_freeK; asynchronous to clk.
- o_busy  out  1  high in any state except IDLE.
- o_grant_idx  out  IDX_W  index of current/last grant.
- o_err_timeout  out  1  sticky; set on watchdog expiry.
- o_err_spurious  out  1  sticky; set on free edge from a non-granted index.
- o_to_idx  out  IDX_W  index that timed out; last one wins.
- i_err_clr  in  1  clears both sticky flags and o_to_idx (one cycle).

Behaviour:
Reset values:
- All outputs 0.
- State IDLE; round-robin pointer last = N_REQ-1, so the first grant goes to the lowest index ≥0.
- Synchronizer flops and edge-detect history cleared.

Free synchronization:
- Each i_free bit passes SYNC_STAGES flops, then a rising-edge detector: fr[k] = s[k] & ~s_d[k].
- Only edges count. A level held high produces a single event.

FSM (IDLE, DRIVE, WAIT, GAP):
- IDLE: if |i_req, pick the first set bit searching last+1 .. N_REQ-1, 0 .. last. Register g, o_grant_idx=g, go DRIVE. The decision is made in the cycle req is seen; o_drive rises the next cycle.
- DRIVE: o_drive[g]=1 for exactly one cycle. Clear cnt; go WAIT.
- WAIT: cnt increments each cycle.
  - If fr[g]: o_ack[g]=1 (registered, next cycle), last=g, go GAP.
  - Else if cnt==TIMEOUT-1: set o_err_timeout, o_to_idx=g, last=g, no ack, go GAP.
  - Free takes precedence over timeout in the same cycle.
- GAP: count GAP_CYC cycles, then IDLE. No grant is issued during GAP. This guarantees the merge's tap has returned to idle before the next drive.

Fixed latencies:
- Minimum req-to-drive: 1 cycle.
- Drive-to-ack: free latency + SYNC_STAGES + 2 cycles.
- Back-to-back grants: separated by at least GAP_CYC+1 idle drive cycles.

Boundary and error cases:
- fr[k] with k≠g, or any fr in IDLE/DRIVE/GAP: ignored for FSM purposes; sets o_err_spurious.
- Requester drops i_req after grant: the transaction completes normally; ack is still pulsed.
- All N_REQ requesting: strict rotation, each served exactly once per N_REQ transactions.
- Single requester continuously requesting: served every transaction; pointer wrap is harmless.
- i_err_clr coincident with a new error: the new error wins (set has priority over clear).
- rst mid-WAIT: immediate return to reset state. No ack or drive is emitted; any late free is absorbed as spurious only if it arrives after reset deasserts.
- o_drive is guaranteed one-hot or zero at all times; assert this in RTL.

Decomposition:
- Shared package merge_sched_pkg: state enum (IDLE, DRIVE, WAIT, GAP), and default constants for N_REQ, TIMEOUT, GAP_CYC.
- One sub-module rr_pick: combinational round-robin priority picker. Inputs are req vector and last pointer; outputs are valid and index. It is reusable for other merge widths.
- The synchronizer is instantiated per bit as a generate loop inside the top.

Test Plan:
1. Reset then i_req=9'h001; model merge returns free 5 cycles after drive. Expect:
   - o_drive[0] one cycle, 1 cycle after req.
   - o_ack[0] at drive+5+SYNC_STAGES+2.
   - o_busy low again after GAP_CYC.
2. i_req=9'h1FF held; auto-ack model. Expect grant order 0,1,…,8,0,1. There must be no duplicate before all 9 are served, and o_drive is never multi-hot.
3. i_req=9'h010 with free never returned (TIMEOUT=16). Expect:
   - o_err_timeout=1 and o_to_idx=4 at drive+16.
   - No o_ack.
   - Next request to index 5 is granted normally.
4. While index 2 is granted, pulse i_free[7]. Expect o_err_spurious=1, FSM still in WAIT for 2, and a correct ack[2] on the real free. Then pulse i_err_clr: both flags clear.
5. Assert rst during WAIT for index 3. Expect all outputs 0 next cycle and pointer reset. After release with i_req=9'h108, the first grant goes to index 3.
6. Free edge and timeout expiry in the same cycle (TIMEOUT=8, free arriving at cnt=7). Expect o_ack pulsed and o_err_timeout remains 0.

Source files
------------

// File: rtl/merge_sched_pkg.sv
// Shared constants and FSM encoding for the round-robin scheduler in front of the
// mutex stream merge.
package merge_sched_pkg;

  localparam int unsigned DefNReq       = 9;
  localparam int unsigned DefTimeout    = 1024;
  localparam int unsigned DefGapCyc     = 2;
  localparam int unsigned DefSyncStages = 2;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StDrive = 2'd1;
  localparam state_t StWait  = 2'd2;
  localparam state_t StGap   = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_i,
// wrapping around and ending at last_i itself.
module rr_pick #(
  parameter int unsigned  NReq = 9,
  localparam int unsigned IdxW = $clog2(NReq)
) (
  input  logic [NReq-1:0] req_i,
  input  logic [IdxW-1:0] last_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  logic [IdxW-1:0] cand;

  // Walk from the farthest offset to the nearest so the nearest hit is written last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = int'(NReq); i >= 1; i--) begin
      cand = IdxW'((int'(last_i) + i) % int'(NReq));
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/stream_merge_rr_sched.sv
// Round-robin drive scheduler for the mutex stream merge: one grant at a time, waits
// for the granted input's free edge, acks the producer, then idles for a recovery gap.
module stream_merge_rr_sched
  import merge_sched_pkg::*;
#(
  parameter int unsigned  N_REQ       = DefNReq,
  parameter int unsigned  TIMEOUT     = DefTimeout,
  parameter int unsigned  GAP_CYC     = DefGapCyc,
  parameter int unsigned  SYNC_STAGES = DefSyncStages,
  localparam int unsigned IDX_W       = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_ack,
  output logic [N_REQ-1:0] o_drive,
  input  logic [N_REQ-1:0] i_free,
  output logic             o_busy,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_err_timeout,
  output logic             o_err_spurious,
  output logic [IDX_W-1:0] o_to_idx,
  input  logic             i_err_clr
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam int unsigned GapW = $clog2(GAP_CYC + 1);

  logic [N_REQ-1:0] free_s, free_d_q, fr_q;

  for (genvar k = 0; k < N_REQ; k++) begin : g_sync
    logic [SYNC_STAGES-1:0] stg_q;
    always_ff @(posedge clk) begin
      if (rst) stg_q <= '0;
      else     stg_q <= {stg_q[SYNC_STAGES-2:0], i_free[k]};
    end
    assign free_s[k] = stg_q[SYNC_STAGES-1];
  end

  // Edge pulse is registered so the FSM only ever sees a flop output.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_d_q <= '0;
      fr_q     <= '0;
    end else begin
      free_d_q <= free_s;
      fr_q     <= free_s & ~free_d_q;
    end
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] gnt_q, gnt_d, last_q, last_d, to_idx_q, to_idx_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [N_REQ-1:0] drive_q, drive_d, ack_q, ack_d, gnt_oh, pick_oh;
  logic             to_err_q, to_err_d, sp_err_q, sp_err_d;
  logic             to_set, spur_set, pick_valid;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(
    .NReq (N_REQ)
  ) u_rr_pick (
    .req_i   (i_req),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign gnt_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_q;
  assign pick_oh = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    drive_d = '0;
    ack_d   = '0;
    to_set  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d   = pick_idx;
          drive_d = pick_oh;
          cnt_d   = '0;
          state_d = StDrive;
        end
      end
      StDrive: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (fr_q[gnt_q]) begin
          ack_d   = gnt_oh;
          last_d  = gnt_q;
          gap_d   = '0;
          state_d = StGap;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          to_set  = 1'b1;
          last_d  = gnt_q;
          gap_d   = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GapW'(GAP_CYC - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    spur_set = (state_q == StWait) ? |(fr_q & ~gnt_oh) : |fr_q;
    // A new error beats a coincident clear.
    to_err_d = to_set | (to_err_q & ~i_err_clr);
    sp_err_d = spur_set | (sp_err_q & ~i_err_clr);
    to_idx_d = to_set ? gnt_q : (i_err_clr ? '0 : to_idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      last_q   <= IDX_W'(N_REQ - 1);
      cnt_q    <= '0;
      gap_q    <= '0;
      drive_q  <= '0;
      ack_q    <= '0;
      to_err_q <= 1'b0;
      sp_err_q <= 1'b0;
      to_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      drive_q  <= drive_d;
      ack_q    <= ack_d;
      to_err_q <= to_err_d;
      sp_err_q <= sp_err_d;
      to_idx_q <= to_idx_d;
    end
  end

  assign o_drive        = drive_q;
  assign o_ack          = ack_q;
  assign o_busy         = (state_q != StIdle);
  assign o_grant_idx    = gnt_q;
  assign o_err_timeout  = to_err_q;
  assign o_err_spurious = sp_err_q;
  assign o_to_idx       = to_idx_q;

  a_drive_onehot: assert property (@(posedge clk) $onehot0(drive_q));

endmodule
